add_sub_result_stage: RTL and testbench

- Registered capture stage directly downstream of the 4-bit adder/subtractor (adder_sub_ckt).
- Latches the combinational sum/carry together with operand sign bits and mode, and derives ALU flags.
- Buffers results in a small FIFO with valid/ready handshakes so the consumer may stall without losing results.
- Keeps running operation and overflow statistics.

---
 rtl/add_sub_result_stage.sv | 152 +++++++++++++++
 tb/tb_add_sub_result_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_result_stage.sv
// Registered capture stage for the 4-bit adder/subtractor: derives ALU flags,
// buffers results in a small FIFO with valid/ready handshakes, keeps op/overflow statistics.
//
// state       | meaning
// OCC_EMPTY   | count == 0, no head entry, out_valid low
// OCC_PARTIAL | 0 < count < DEPTH, push and pop both possible
// OCC_FULL    | count == DEPTH, in_ready low, in_valid ignored
module add_sub_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       sum_in,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             mode_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_sub,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE_CNT  = OCC_W'(1);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  // entry layout: {sub, v, c, n, z, sum[3:0]}
  logic [8:0]       r_mem [DEPTH];
  logic [8:0]       r_head;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_ovf_count;

  occ_t             w_occ;
  logic             w_push;
  logic             w_pop;
  logic             w_z;
  logic             w_c;
  logic             w_v;
  logic [8:0]       w_entry;
  logic [8:0]       w_head_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [OCC_W-1:0] w_count_nxt;

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0) begin
      w_occ = OCC_EMPTY;
    end else if (r_count == FULL_CNT) begin
      w_occ = OCC_FULL;
    end
  end

  assign in_ready  = (w_occ != OCC_FULL);
  assign out_valid = (w_occ != OCC_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_z = (sum_in[3:0] == 4'd0);
  assign w_c = sum_in[4] ^ mode_in;
  // signed overflow: operands effectively share sign (add) or differ (sub) and result sign flips
  assign w_v = (mode_in ? (a_msb != b_msb) : (a_msb == b_msb)) && (sum_in[3] != a_msb);
  assign w_entry = {mode_in, w_v, w_c, sum_in[3], w_z, sum_in[3:0]};

  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + ONE_CNT;
      2'b01:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // The head register mirrors the oldest entry and simply holds once the FIFO drains.
  always_comb begin
    w_head_nxt = r_head;
    if (w_push && ((r_count == '0) || (w_pop && (r_count == ONE_CNT)))) begin
      w_head_nxt = w_entry;
    end else if (w_pop && (r_count > ONE_CNT)) begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count  <= '0;
      r_ovf_count <= '0;
    end else if (w_push) begin
      r_op_count <= r_op_count + 1'b1;
      if (w_v && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  assign result    = r_head[3:0];
  assign flag_z    = r_head[4];
  assign flag_n    = r_head[5];
  assign flag_c    = r_head[6];
  assign flag_v    = r_head[7];
  assign flag_sub  = r_head[8];
  assign op_count  = r_op_count;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_add_sub_result_stage.sv
// Self-checking bench for add_sub_result_stage: operand-level reference model with a
// per-cycle compare process, plus directed literal checks for the key scenarios.
module tb_add_sub_result_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       sum_in;
  logic             a_msb;
  logic             b_msb;
  logic             mode_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_sub;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] ovf_count;

  add_sub_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_sub  (flag_sub),
    .op_count  (op_count),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  // upstream adder emulation: operands in, 5-bit adder output out
  logic [3:0] drv_a;
  logic [3:0] drv_b;
  logic       drv_mode;
  assign sum_in  = drv_mode ? ({1'b0, drv_a} + {1'b0, ~drv_b} + 5'd1)
                            : ({1'b0, drv_a} + {1'b0, drv_b});
  assign a_msb   = drv_a[3];
  assign b_msb   = drv_b[3];
  assign mode_in = drv_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       sub;
    logic       v;
    logic       c;
    logic       n;
    logic       z;
    logic [3:0] r;
  } ent_t;

  // expected entry from true integer arithmetic on the operands
  function automatic ent_t expect_entry(input logic [3:0] a, input logic [3:0] b, input logic sub);
    ent_t e;
    int ua, ub, sa, sb, raw, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    raw = sub ? ua - ub : ua + ub;
    sr  = sub ? sa - sb : sa + sb;
    e.r   = 4'(raw & 15);
    e.z   = ((raw & 15) == 0);
    e.n   = ((raw & 15) >= 8);
    e.c   = sub ? (ua < ub) : (raw > 15);
    e.v   = (sr < -8) || (sr > 7);
    e.sub = sub;
    return e;
  endfunction

  ent_t q[$];
  ent_t m_head;
  ent_t m_new;
  int   m_op;
  int   m_ovf;
  bit   m_push;
  bit   m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_head = '0;
      m_op   = 0;
      m_ovf  = 0;
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = out_ready && (q.size() > 0);
      m_new  = expect_entry(drv_a, drv_b, drv_mode);
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(m_new);
        m_op = (m_op + 1) % (1 << CNT_W);
        if (m_new.v && (m_ovf < (1 << CNT_W) - 1)) m_ovf++;
      end
      if (q.size() > 0) m_head = q[0];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_out_valid", out_valid, (q.size() > 0));
      chk("model_in_ready", in_ready, (q.size() < DEPTH));
      chk("model_result", result, m_head.r);
      chk("model_flags_zncvs", {flag_z, flag_n, flag_c, flag_v, flag_sub},
          {m_head.z, m_head.n, m_head.c, m_head.v, m_head.sub});
      chk("model_op_count", op_count, m_op);
      chk("model_ovf_count", ovf_count, m_ovf);
    end
  end

  // called at a negedge; returns at the negedge following the accepting edge
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic sub);
    bit acc;
    acc = 0;
    drv_a    = a;
    drv_b    = b;
    drv_mode = sub;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drv_a     = 4'd0;
    drv_b     = 4'd0;
    drv_mode  = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_counts", {op_count, ovf_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 7 + 1: signed overflow
    push(4'd7, 4'd1, 1'b0);
    chk("add_ovf_valid", out_valid, 1);
    chk("add_ovf_result", result, 8);
    chk("add_ovf_zncv", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
    chk("add_ovf_count", ovf_count, 1);
    // 5 - 5: zero, no borrow
    push(4'd5, 4'd5, 1'b1);
    chk("sub_zero_result", result, 0);
    chk("sub_zero_zncvs", {flag_z, flag_n, flag_c, flag_v, flag_sub}, 5'b10001);
    // 3 - 5: borrow
    push(4'd3, 4'd5, 1'b1);
    chk("sub_borrow_result", result, 14);
    chk("sub_borrow_zncv", {flag_z, flag_n, flag_c, flag_v}, 4'b0110);
    // -7 + -7, -8 - 1, 2 + 3
    push(4'h9, 4'h9, 1'b0);
    chk("neg_add_result", result, 2);
    chk("neg_add_cv", {flag_c, flag_v}, 2'b11);
    push(4'h8, 4'h1, 1'b1);
    chk("neg_sub_result", result, 7);
    chk("neg_sub_cv", {flag_c, flag_v}, 2'b01);
    push(4'd2, 4'd3, 1'b0);
    chk("plain_add_result", result, 5);
    chk("op_count_6", op_count, 6);

    // idle with wiggling inputs: nothing may be captured
    for (int k = 0; k < 4; k++) begin
      drv_a = 4'(k * 5);
      drv_b = 4'(k + 3);
      drv_mode = k[0];
      @(negedge clk);
    end
    chk("idle_empty", out_valid, 0);
    chk("idle_hold_result", result, 5);
    chk("idle_op_count", op_count, 6);

    // backpressure
    out_ready = 1'b0;
    push(4'd1, 4'd2, 1'b0);
    push(4'd3, 4'd4, 1'b0);
    chk("bp_full_in_ready", in_ready, 0);
    drv_a = 4'd6;
    drv_b = 4'd2;
    drv_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_held_in_ready", in_ready, 0);
    chk("bp_held_op_count", op_count, 8);
    chk("bp_head_first", result, 3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop1_in_ready", in_ready, 1);
    chk("bp_pop1_result", result, 7);
    chk("bp_pop1_op_count", op_count, 8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_third_result", result, 8);
    chk("bp_third_op_count", op_count, 9);
    @(negedge clk);

    // asynchronous reset with two entries buffered
    out_ready = 1'b0;
    push(4'd2, 4'd2, 1'b0);
    push(4'd1, 4'd1, 1'b1);
    chk("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_counts", {op_count, ovf_count}, 0);
    chk("arst_result_flags", {result, flag_z, flag_n, flag_c, flag_v, flag_sub}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", out_valid, 0);

    // counter wrap and saturation
    for (int k = 0; k < 255; k++) push(4'd7, 4'd1, 1'b0);
    chk("cnt_255_op", op_count, 255);
    chk("cnt_255_ovf", ovf_count, 255);
    push(4'd7, 4'd1, 1'b0);
    chk("cnt_wrap_op", op_count, 0);
    chk("cnt_sat_ovf", ovf_count, 255);
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
